// File: rtl/input_buffer_rc.sv
// Router input buffer: circular flit FIFO with a per-packet route-computation FSM.
// The head flit's destination goes out to route computation and the returned port is held for the whole packet.
package input_buffer_rc_pkg;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, EAST, WEST} port_t;

  typedef struct packed {
    flit_label_t flit_label;
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [15:0] payload;
  } flit_t;
endpackage

module input_buffer_rc
  import input_buffer_rc_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE      = 8,
  parameter int unsigned DEST_ADDR_SIZE_X = 4,
  parameter int unsigned DEST_ADDR_SIZE_Y = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  flit_t                       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DEST_ADDR_SIZE_X-1:0] x_dest_o,
  output logic [DEST_ADDR_SIZE_Y-1:0] y_dest_o,
  input  port_t                       out_port_i,
  output port_t                       out_port_o,
  output logic                        route_valid_o,
  output flit_t                       data_o,
  output logic                        valid_o,
  input  logic                        read_i,
  output logic                        error_o
);

  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(BUFFER_SIZE);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_next;
  flit_t            mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, write_en, pop, latch_route, error_next;
  flit_t            front;

  assign full          = (count == CNT_MAX);
  assign empty         = (count == '0);
  assign ready_o       = !full;
  assign write_en      = valid_i && !full;
  assign front         = mem[rd_ptr];
  assign data_o        = front;
  assign x_dest_o      = DEST_ADDR_SIZE_X'(front.x_dest);
  assign y_dest_o      = DEST_ADDR_SIZE_Y'(front.y_dest);
  assign route_valid_o = (state == ACTIVE);
  assign valid_o       = (state == ACTIVE) && !empty;

  // Storage is not reset; only pointers and count define what is buffered.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    latch_route = 1'b0;
    error_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (front.flit_label inside {HEAD, HEADTAIL}) begin
            latch_route = 1'b1;
            state_next  = ACTIVE;
          end else begin
            pop        = 1'b1;
            error_next = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (read_i && !empty) begin
          pop = 1'b1;
          if (front.flit_label inside {TAIL, HEADTAIL}) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_port_o <= LOCAL;
      error_o    <= 1'b0;
    end else begin
      state   <= state_next;
      error_o <= error_next;
      if (latch_route) begin
        out_port_o <= out_port_i;
      end
      if (write_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({write_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer_rc.sv
// Self-checking bench for input_buffer_rc: directed scenarios plus randomized traffic
// checked by a packet-level scoreboard and a decoupled output monitor.
module tb_input_buffer_rc;
  import input_buffer_rc_pkg::*;

  localparam int unsigned BS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  flit_t      data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [3:0] x_dest_o, y_dest_o;
  port_t      out_port_i, out_port_o;
  logic       route_valid_o;
  flit_t      data_o;
  logic       valid_o;
  logic       read_i = 1'b0;
  logic       error_o;

  input_buffer_rc #(.BUFFER_SIZE(BS), .DEST_ADDR_SIZE_X(4), .DEST_ADDR_SIZE_Y(4)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .x_dest_o(x_dest_o), .y_dest_o(y_dest_o), .out_port_i(out_port_i),
    .out_port_o(out_port_o), .route_valid_o(route_valid_o), .data_o(data_o),
    .valid_o(valid_o), .read_i(read_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // XY routing for a router sitting at (2,2)
  function automatic port_t route(input logic [3:0] x, input logic [3:0] y);
    if (x > 4'd2)      return EAST;
    else if (x < 4'd2) return WEST;
    else if (y > 4'd2) return NORTH;
    else if (y < 4'd2) return SOUTH;
    else               return LOCAL;
  endfunction

  always_comb out_port_i = route(x_dest_o, y_dest_o);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level reference: a flit is delivered iff it belongs to a packet opened by a head
  typedef struct {
    flit_t f;
    port_t p;
  } exp_t;

  exp_t  exp_q[$];
  int    exp_err = 0;
  int    got_err = 0;
  bit    in_pkt  = 1'b0;
  port_t cur_port = LOCAL;

  function automatic void model_accept(input flit_t f);
    exp_t e;
    if (!in_pkt) begin
      if (f.flit_label == HEAD || f.flit_label == HEADTAIL) begin
        cur_port = route(f.x_dest, f.y_dest);
        e.f = f; e.p = cur_port;
        exp_q.push_back(e);
        in_pkt = (f.flit_label == HEAD);
      end else begin
        exp_err++;
      end
    end else begin
      e.f = f; e.p = cur_port;
      exp_q.push_back(e);
      if (f.flit_label == TAIL || f.flit_label == HEADTAIL) in_pkt = 1'b0;
    end
  endfunction

  function automatic flit_t mk(input flit_label_t l, input int unsigned x, input int unsigned y,
                               input int unsigned pl);
    flit_t f;
    f.flit_label = l;
    f.x_dest     = 4'(x);
    f.y_dest     = 4'(y);
    f.payload    = 16'(pl);
    return f;
  endfunction

  // Output monitor: every pop must match the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (error_o) got_err++;
        if (valid_o && read_i) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pop: got flit %0h expected none", data_o);
          end else begin
            e = exp_q.pop_front();
            check("data_o", data_o, e.f);
            check("out_port_o", out_port_o, e.p);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Callers are always at posedge+1 and return there
  task automatic send(input flit_t f);
    int unsigned n = 0;
    data_i  = f;
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("send_timeout", 32'(ready_o), 1);
    else model_accept(f);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    read_i = 1'b1;
    while ((exp_q.size() != 0 || valid_o) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    rst     = 1'b1;
    valid_i = 1'b0;
    read_i  = 1'b0;
    #1;
    check("rst_count", 32'(dut.count), 0);
    check("rst_valid_o", 32'(valid_o), 0);
    check("rst_route_valid_o", 32'(route_valid_o), 0);
    check("rst_out_port_o", 32'(out_port_o), 32'(LOCAL));
    check("rst_ready_o", 32'(ready_o), 1);
    check("rst_error_o", 32'(error_o), 0);
    exp_q.delete();
    in_pkt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit done;
    apply_reset();

    // Three-flit packet, route latched one edge after the head write
    send(mk(HEAD, 3, 1, 16'h1111));
    check("hd_route_valid_e1", 32'(route_valid_o), 0);
    check("hd_valid_e1", 32'(valid_o), 0);
    send(mk(BODY, 0, 0, 16'h2222));
    check("hd_route_valid_e2", 32'(route_valid_o), 1);
    check("hd_valid_e2", 32'(valid_o), 1);
    check("hd_out_port_e2", 32'(out_port_o), 32'(EAST));
    check("hd_x_dest", 32'(x_dest_o), 3);
    check("hd_y_dest", 32'(y_dest_o), 1);
    send(mk(TAIL, 0, 0, 16'h3333));
    drain();
    check("hd_idle_after_tail", 32'(route_valid_o), 0);

    // Fill to full, hold a ninth write, then pop once with valid_i still high
    apply_reset();
    send(mk(HEAD, 4, 4, 16'h0100));
    for (int unsigned i = 1; i < BS; i++) send(mk(BODY, 0, 0, 16'h0100 + i));
    check("full_ready_o", 32'(ready_o), 0);
    check("full_count", 32'(dut.count), BS);
    data_i  = mk(TAIL, 0, 0, 16'h01FF);
    valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("full_hold_ready_o", 32'(ready_o), 0);
    end
    check("full_hold_count", 32'(dut.count), BS);
    read_i = 1'b1;
    @(posedge clk); #1;
    read_i = 1'b0;
    check("full_pop_ready_o", 32'(ready_o), 1);
    check("full_pop_count", 32'(dut.count), BS - 1);
    send(mk(TAIL, 0, 0, 16'h01FF));
    drain();

    // HEADTAIL then HEAD: one flit on NORTH, one IDLE cycle, then WEST
    apply_reset();
    read_i = 1'b1;
    send(mk(HEADTAIL, 2, 3, 16'h0A0A));
    send(mk(HEAD, 0, 1, 16'h0B0B));
    check("ht_port_north", 32'(out_port_o), 32'(NORTH));
    check("ht_active", 32'(route_valid_o), 1);
    @(posedge clk); #1;
    check("ht_idle_gap", 32'(route_valid_o), 0);
    @(posedge clk); #1;
    check("ht_active_again", 32'(route_valid_o), 1);
    check("ht_port_west", 32'(out_port_o), 32'(WEST));
    send(mk(TAIL, 0, 0, 16'h0C0C));
    drain();

    // Orphan BODY in IDLE is discarded with a one-cycle error pulse
    apply_reset();
    send(mk(BODY, 1, 1, 16'hDEAD));
    check("orph_count_e1", 32'(dut.count), 1);
    check("orph_error_e1", 32'(error_o), 0);
    @(posedge clk); #1;
    check("orph_error_e2", 32'(error_o), 1);
    check("orph_count_e2", 32'(dut.count), 0);
    check("orph_valid_e2", 32'(valid_o), 0);
    @(posedge clk); #1;
    check("orph_error_e3", 32'(error_o), 0);
    check("orph_valid_e3", 32'(valid_o), 0);

    // Asynchronous reset with a packet in flight
    apply_reset();
    send(mk(HEAD, 5, 2, 16'h5000));
    send(mk(BODY, 0, 0, 16'h5001));
    send(mk(BODY, 0, 0, 16'h5002));
    check("mid_route_valid", 32'(route_valid_o), 1);
    check("mid_count", 32'(dut.count), 3);
    apply_reset();

    // Long packet streamed through to exercise pointer wrap
    read_i = 1'b1;
    send(mk(HEAD, 0, 4, 16'h7000));
    for (int unsigned i = 1; i < 3 * BS - 1; i++) send(mk(BODY, 0, 0, 16'h7000 + i));
    send(mk(TAIL, 0, 0, 16'h7FFF));
    drain();

    // Randomized traffic with random read backpressure
    done = 1'b0;
    fork
      begin
        for (int unsigned i = 0; i < 250; i++) begin
          int unsigned r;
          flit_label_t l;
          r = $urandom_range(0, 9);
          if (r < 2)       l = HEAD;
          else if (r == 2) l = HEADTAIL;
          else if (r == 3) l = TAIL;
          else             l = BODY;
          send(mk(l, $urandom_range(0, 15), $urandom_range(0, 15), $urandom));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        send(mk(TAIL, 0, 0, 16'hFFFF));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          read_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("final_count", 32'(dut.count), 0);
    check("error_pulses", got_err, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
